// File: rtl/detector_jogada_filtrado.sv
// Debounced single-key play detector for the memory game: filters chaves, registers one-hot plays, pulses on release.
// Optional macro DETECTOR_JOGADA_ERRO_EN adds a one-cycle jogada_invalida pulse for multi-key presses.
module detector_jogada_filtrado #(
    parameter int DEBOUNCE_CICLOS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] chaves,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       tem_jogada,
`ifdef DETECTOR_JOGADA_ERRO_EN
    output logic       jogada_invalida,
`endif
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        ESPERA      = 3'd0,
        FILTRA      = 3'd1,
        PRESSIONADA = 3'd2,
        SOLTA       = 3'd3,
        EMITE       = 3'd4,
        INVALIDA    = 3'd5
    } estado_t;

    localparam logic [3:0] ULTIMO = 4'(DEBOUNCE_CICLOS - 1);

    estado_t    estado;
    estado_t    proximo;
    logic [3:0] amostra;
    logic [3:0] contador;
    logic       amostra_onehot;

    assign amostra_onehot = (amostra != 4'b0000) && ((amostra & (amostra - 4'd1)) == 4'b0000);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= ESPERA;
        end else begin
            estado <= proximo;
        end
    end

    // Datapath registers: sampled key, debounce counter and the accepted play
    always_ff @(posedge clock) begin
        if (reset) begin
            amostra  <= 4'b0000;
            contador <= 4'd0;
            jogada   <= 4'b0000;
        end else begin
            case (estado)
                ESPERA: begin
                    if (habilita && chaves != 4'b0000) begin
                        amostra  <= chaves;
                        contador <= 4'd0;
                    end
                end
                FILTRA: begin
                    if (chaves == amostra) begin
                        if (contador == ULTIMO) begin
                            if (amostra_onehot) begin
                                jogada <= amostra;
                            end
                        end else begin
                            contador <= contador + 4'd1;
                        end
                    end
                end
                PRESSIONADA: begin
                    if (chaves == 4'b0000) begin
                        contador <= 4'd0;
                    end
                end
                SOLTA: begin
                    if (chaves == 4'b0000 && contador != ULTIMO) begin
                        contador <= contador + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            ESPERA: begin
                if (habilita && chaves != 4'b0000) begin
                    proximo = FILTRA;
                end
            end
            FILTRA: begin
                if (chaves != amostra) begin
                    proximo = ESPERA;
                end else if (contador == ULTIMO) begin
                    proximo = amostra_onehot ? PRESSIONADA : INVALIDA;
                end
            end
            PRESSIONADA: begin
                if (chaves == 4'b0000) begin
                    proximo = SOLTA;
                end
            end
            SOLTA: begin
                if (chaves != 4'b0000) begin
                    proximo = PRESSIONADA;
                end else if (contador == ULTIMO) begin
                    proximo = EMITE;
                end
            end
            EMITE: begin
                proximo = ESPERA;
            end
            INVALIDA: begin
                if (chaves == 4'b0000) begin
                    proximo = ESPERA;
                end
            end
            default: begin
                proximo = ESPERA;
            end
        endcase
    end

    always_comb begin
        jogada_feita = (estado == EMITE);
        tem_jogada   = (estado == PRESSIONADA) || (estado == SOLTA);
        db_estado    = estado;
    end

`ifdef DETECTOR_JOGADA_ERRO_EN
    // High during the first cycle spent in INVALIDA only
    always_ff @(posedge clock) begin
        if (reset) begin
            jogada_invalida <= 1'b0;
        end else begin
            jogada_invalida <= (estado == FILTRA) && (proximo == INVALIDA);
        end
    end
`endif

endmodule
